execute_xm: RTL and testbench

Execute stage plus X/M pipeline latch of the 5-stage core. Consumes the registered D/X fields (opcode, ALU opcode, shamt, operands, sign-extended immediate, zero-extended target, PC+1, rd address). Computes ALU results, resolves branches and jumps, and runs an iterative multiply/divide that stalls the front end. Registers the result for the memory stage.

---
 rtl/proc_pkg.sv | 49 ++++
 rtl/multdiv_iter.sv | 95 +++++++++
 rtl/execute_xm.sv | 142 ++++++++++++++
 tb/tb_execute_xm.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants, exception codes and multiply/divide FSM state for the core pipeline.
package proc_pkg;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   localparam logic [31:0] EXC_ADD  = 32'd1;
   localparam logic [31:0] EXC_ADDI = 32'd2;
   localparam logic [31:0] EXC_SUB  = 32'd3;
   localparam logic [31:0] EXC_MUL  = 32'd4;
   localparam logic [31:0] EXC_DIV0 = 32'd5;

   localparam logic [4:0] REG_LINK   = 5'd31;
   localparam logic [4:0] REG_STATUS = 5'd30;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   // Two's-complement overflow of a+b given the sign bits of both operands and the sum.
   function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
      return (sa == sb) && (ss != sa);
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (32'd0 - x) : x;
   endfunction

endpackage

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (shift-add) and divide (restoring) on operand magnitudes,
// one bit per BUSY cycle; sign is reapplied to the finished magnitude.
module multdiv_iter
   import proc_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        is_div,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        overflow
);
   localparam int CW = $clog2(MD_CYCLES);

   md_state_t     state_r, state_s;
   logic [CW-1:0] count_r;
   logic          div_r, neg_r;
   logic [63:0]   acc_r, mcand_r;
   logic [31:0]   mplier_r, rem_r, quo_r, divisor_r;
   logic [32:0]   shifted_s;
   logic [33:0]   trial_s;
   logic [63:0]   prod_s;

   always_ff @(posedge clock) begin
      if (!reset_n) state_r <= MD_IDLE;
      else          state_r <= state_s;
   end

   always_comb begin
      state_s = state_r;
      case (state_r)
         MD_IDLE: if (start) state_s = MD_BUSY; else state_s = MD_IDLE;
         MD_BUSY: if (count_r == CW'(MD_CYCLES - 1)) state_s = MD_DONE; else state_s = MD_BUSY;
         MD_DONE: state_s = MD_IDLE;
         default: state_s = MD_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_r == MD_BUSY);
      done = (state_r == MD_DONE);
   end

   assign shifted_s = {rem_r, quo_r[31]};
   assign trial_s   = {1'b0, shifted_s} - {2'b00, divisor_r};

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_r   <= '0;
         div_r     <= 1'b0;
         neg_r     <= 1'b0;
         acc_r     <= 64'd0;
         mcand_r   <= 64'd0;
         mplier_r  <= 32'd0;
         rem_r     <= 32'd0;
         quo_r     <= 32'd0;
         divisor_r <= 32'd0;
      end else if (start && state_r == MD_IDLE) begin
         count_r   <= '0;
         div_r     <= is_div;
         neg_r     <= op_a[31] ^ op_b[31];
         acc_r     <= 64'd0;
         mcand_r   <= {32'd0, abs32(op_a)};
         mplier_r  <= abs32(op_b);
         rem_r     <= 32'd0;
         quo_r     <= abs32(op_a);
         divisor_r <= abs32(op_b);
      end else if (state_r == MD_BUSY) begin
         count_r <= count_r + CW'(1);
         if (div_r) begin
            // Quotient bits shift into quo_r as the dividend bits shift out of it.
            rem_r <= trial_s[33] ? shifted_s[31:0] : trial_s[31:0];
            quo_r <= {quo_r[30:0], ~trial_s[33]};
         end else begin
            if (mplier_r[0]) acc_r <= acc_r + mcand_r;
            else             acc_r <= acc_r;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
         end
      end else begin
         count_r <= count_r;
      end
   end

   assign prod_s   = neg_r ? (64'd0 - acc_r) : acc_r;
   assign result   = div_r ? (neg_r ? (32'd0 - quo_r) : quo_r) : prod_s[31:0];
   assign overflow = div_r ? 1'b0 : (prod_s[63:32] != {32{prod_s[31]}});

endmodule

// File: rtl/execute_xm.sv
// Execute stage and X/M latch: ALU, branch resolution and an optional iterative
// multiply/divide (present only when MULTDIV_EN is defined).
module execute_xm
   import proc_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic        clock,
   input  logic        XM_reset_n,
   input  logic [4:0]  opcode,
   input  logic [4:0]  ALUopcode,
   input  logic [4:0]  shamt,
   input  logic [31:0] regA,
   input  logic [31:0] regB,
   input  logic [31:0] immediate,
   input  logic [31:0] target,
   input  logic [31:0] PCplusone,
   input  logic [4:0]  rd_address,
   output logic        stall,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic [4:0]  XM_opcode,
   output logic [4:0]  XM_rd_address,
   output logic [31:0] XM_result,
   output logic [31:0] XM_regB
);
   logic        is_md_s, is_div_s, taken_s;
   logic [31:0] sum_ab_s, dif_ab_s, sum_ai_s, res_s, md_value_s, md_code_s;
   logic        md_exc_s;
   logic [4:0]  rd_s;

   assign is_div_s = (ALUopcode == ALU_DIV);
   assign is_md_s  = (opcode == OP_ALU) && ((ALUopcode == ALU_MUL) || is_div_s);
   assign sum_ab_s = regA + regB;
   assign dif_ab_s = regA - regB;
   assign sum_ai_s = regA + immediate;

`ifdef MULTDIV_EN
   logic        md_busy_s, md_done_s, md_ovf_s, md_start_s;
   logic [31:0] md_result_s;

   assign md_start_s = is_md_s && !md_busy_s && !md_done_s;
   assign stall      = XM_reset_n && (md_start_s || md_busy_s);

   multdiv_iter #(.MD_CYCLES(MD_CYCLES)) u_multdiv (
      .clock    (clock),
      .reset_n  (XM_reset_n),
      .start    (md_start_s),
      .is_div   (is_div_s),
      .op_a     (regA),
      .op_b     (regB),
      .busy     (md_busy_s),
      .done     (md_done_s),
      .result   (md_result_s),
      .overflow (md_ovf_s)
   );

   // Divide-by-zero is flagged from the operand, which is held constant for the whole operation.
   always_comb begin
      md_value_s = md_result_s;
      if (is_div_s) begin
         md_exc_s  = (regB == 32'd0);
         md_code_s = EXC_DIV0;
      end else begin
         md_exc_s  = md_ovf_s;
         md_code_s = EXC_MUL;
      end
   end
`else
   logic [31:0] cfg_unused_s;

   assign cfg_unused_s = 32'(MD_CYCLES);
   assign stall        = 1'b0;
   assign md_value_s   = 32'd0;
   assign md_exc_s     = 1'b0;
   assign md_code_s    = 32'd0;
`endif

   always_comb begin
      res_s = 32'd0;
      rd_s  = rd_address;
      case (opcode)
         OP_ALU: begin
            case (ALUopcode)
               ALU_ADD: if (add_ovf(regA[31], regB[31], sum_ab_s[31])) begin
                           res_s = EXC_ADD; rd_s = REG_STATUS;
                        end else res_s = sum_ab_s;
               ALU_SUB: if (add_ovf(regA[31], ~regB[31], dif_ab_s[31])) begin
                           res_s = EXC_SUB; rd_s = REG_STATUS;
                        end else res_s = dif_ab_s;
               ALU_AND: res_s = regA & regB;
               ALU_OR:  res_s = regA | regB;
               ALU_SLL: res_s = regA << shamt;
               ALU_SRA: res_s = $signed(regA) >>> shamt;
               ALU_MUL, ALU_DIV:
                        if (md_exc_s) begin
                           res_s = md_code_s; rd_s = REG_STATUS;
                        end else res_s = md_value_s;
               default: res_s = 32'd0;
            endcase
         end
         OP_ADDI: if (add_ovf(regA[31], immediate[31], sum_ai_s[31])) begin
                     res_s = EXC_ADDI; rd_s = REG_STATUS;
                  end else res_s = sum_ai_s;
         OP_LW, OP_SW: res_s = sum_ai_s;
         OP_JAL:  begin res_s = PCplusone; rd_s = REG_LINK; end
         OP_SETX: begin res_s = target; rd_s = REG_STATUS; end
         default: res_s = 32'd0;
      endcase
   end

   always_comb begin
      taken_s       = 1'b0;
      branch_target = 32'd0;
      case (opcode)
         OP_BNE:        begin taken_s = (regA != regB); branch_target = PCplusone + immediate; end
         OP_BLT:        begin taken_s = ($signed(regA) < $signed(regB)); branch_target = PCplusone + immediate; end
         OP_J, OP_JAL:  begin taken_s = 1'b1; branch_target = target; end
         OP_JR:         begin taken_s = 1'b1; branch_target = regA; end
         OP_BEX:        begin taken_s = (regA != 32'd0); branch_target = target; end
         default:       begin taken_s = 1'b0; branch_target = 32'd0; end
      endcase
   end

   assign branch_taken = taken_s && !stall;

   // Stalled cycles load a bubble so nothing retires while multdiv is in flight.
   always_ff @(posedge clock) begin
      if (!XM_reset_n || stall) begin
         XM_opcode     <= 5'd0;
         XM_rd_address <= 5'd0;
         XM_result     <= 32'd0;
         XM_regB       <= 32'd0;
      end else begin
         XM_opcode     <= opcode;
         XM_rd_address <= rd_s;
         XM_result     <= res_s;
         XM_regB       <= regB;
      end
   end

endmodule

// File: tb/tb_execute_xm.sv
// Scoreboard bench for execute_xm; the multdiv sequences run when MULTDIV_EN is defined.
module tb_execute_xm;
   import proc_pkg::*;

   logic        clock = 1'b0;
   logic        XM_reset_n;
   logic [4:0]  opcode, ALUopcode, shamt, rd_address;
   logic [31:0] regA, regB, immediate, target, PCplusone;
   logic        stall, branch_taken;
   logic [31:0] branch_target, XM_result, XM_regB;
   logic [4:0]  XM_opcode, XM_rd_address;

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] rb;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   execute_xm dut (
      .clock(clock), .XM_reset_n(XM_reset_n), .opcode(opcode), .ALUopcode(ALUopcode),
      .shamt(shamt), .regA(regA), .regB(regB), .immediate(immediate), .target(target),
      .PCplusone(PCplusone), .rd_address(rd_address), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target), .XM_opcode(XM_opcode),
      .XM_rd_address(XM_rd_address), .XM_result(XM_result), .XM_regB(XM_regB)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] tgt, input logic [31:0] pc, input logic [4:0] rd);
      opcode = op; ALUopcode = alu; shamt = sh; regA = a; regB = b;
      immediate = imm; target = tgt; PCplusone = pc; rd_address = rd;
   endtask

   // Drives one instruction, counts stall cycles, then compares the X/M latch after the retiring edge.
   task automatic issue(input string tag, input logic [4:0] op, input logic [4:0] alu,
                        input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [31:0] eres, input logic [4:0] erd, input int estall);
      exp_t e;
      int   n;
      drive(op, alu, sh, a, b, imm, 32'h0000_1234, 32'd200, rd);
      sb.push_back('{op: op, rd: erd, res: eres, rb: b});
      n = 0;
      #1;
      while (stall && n < 200) begin
         n++;
         @(posedge clock); #1;
         if (n == 2) check({tag, "_bubble_rd"}, {27'd0, XM_rd_address}, 32'd0);
      end
      check({tag, "_stall_len"}, n, estall);
      @(posedge clock); #1;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_result"}, XM_result, e.res);
         check({tag, "_rd"}, {27'd0, XM_rd_address}, {27'd0, e.rd});
         check({tag, "_opcode"}, {27'd0, XM_opcode}, {27'd0, e.op});
         check({tag, "_regB"}, XM_regB, e.rb);
      end
   endtask

   task automatic branch(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] tgt,
                         input logic [31:0] pc, input logic etaken, input logic [31:0] etgt);
      drive(op, 5'd0, 5'd0, a, b, imm, tgt, pc, 5'd0);
      #1;
      check({tag, "_taken"}, {31'd0, branch_taken}, {31'd0, etaken});
      if (etaken) check({tag, "_target"}, branch_target, etgt);
      @(posedge clock); #1;
   endtask

   logic [31:0] ra, ri, er;
   logic [4:0]  erd, rrd;
   longint      s64;

   initial begin
      XM_reset_n = 1'b0;
      drive(OP_ALU, ALU_ADD, 5'd0, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 5'd7);
      repeat (2) @(posedge clock);
      #1;
      check("rst_result", XM_result, 32'd0);
      check("rst_rd", {27'd0, XM_rd_address}, 32'd0);
      check("rst_regB", XM_regB, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      XM_reset_n = 1'b1;

      issue("add_ovf", OP_ALU, ALU_ADD, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd5, EXC_ADD, REG_STATUS, 0);
      issue("sub",     OP_ALU, ALU_SUB, 5'd0, 32'd10, 32'd3, 32'd0, 5'd4, 32'd7, 5'd4, 0);
      issue("sub_ovf", OP_ALU, ALU_SUB, 5'd0, 32'h8000_0000, 32'd1, 32'd0, 5'd4, EXC_SUB, REG_STATUS, 0);
      issue("and",     OP_ALU, ALU_AND, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd6, 32'h0000_F000, 5'd6, 0);
      issue("or",      OP_ALU, ALU_OR,  5'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd6, 32'h0000_FFF0, 5'd6, 0);
      issue("sll",     OP_ALU, ALU_SLL, 5'd4, 32'd1, 32'd0, 32'd0, 5'd8, 32'h0000_0010, 5'd8, 0);
      issue("sra",     OP_ALU, ALU_SRA, 5'd4, 32'h8000_0000, 32'd0, 32'd0, 5'd8, 32'hF800_0000, 5'd8, 0);
      issue("addi_ovf", OP_ADDI, 5'd0, 5'd0, 32'h7FFF_FFFF, 32'd9, 32'd1, 5'd3, EXC_ADDI, REG_STATUS, 0);
      issue("lw_wrap", OP_LW, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd2, 5'd3, 32'd1, 5'd3, 0);
      issue("sw",      OP_SW, 5'd0, 5'd0, 32'h0000_0100, 32'hCAFE_F00D, 32'hFFFF_FFFC, 5'd0, 32'h0000_00FC, 5'd0, 0);
      issue("jal",     OP_JAL, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd2, 32'd200, REG_LINK, 0);
      issue("setx",    OP_SETX, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd2, 32'h0000_1234, REG_STATUS, 0);

      for (int i = 0; i < 8; i++) begin
         ra  = $urandom;
         ri  = $urandom;
         rrd = 5'($urandom_range(1, 29));
         s64 = longint'($signed(ra)) + longint'($signed(ri));
         if (s64 > 64'sd2147483647 || s64 < -64'sd2147483648) begin
            er = 32'd2; erd = 5'd30;
         end else begin
            er = s64[31:0]; erd = rrd;
         end
         issue("addi_rand", OP_ADDI, 5'd0, 5'd0, ra, 32'd0, ri, rrd, er, erd, 0);
      end

      branch("bne_t",  OP_BNE, 32'd3, 32'd4, 32'hFFFF_FFFB, 32'd0, 32'd100, 1'b1, 32'd95);
      branch("bne_nt", OP_BNE, 32'd4, 32'd4, 32'hFFFF_FFFB, 32'd0, 32'd100, 1'b0, 32'd0);
      branch("blt_t",  OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'd0, 32'd50, 1'b1, 32'd58);
      branch("blt_nt", OP_BLT, 32'd1, 32'hFFFF_FFFF, 32'd8, 32'd0, 32'd50, 1'b0, 32'd0);
      branch("j",      OP_J, 32'd0, 32'd0, 32'd0, 32'h0000_0777, 32'd50, 1'b1, 32'h0000_0777);
      branch("jr",     OP_JR, 32'h0000_0ABC, 32'd0, 32'd0, 32'd0, 32'd50, 1'b1, 32'h0000_0ABC);
      branch("bex_nt", OP_BEX, 32'd0, 32'd0, 32'd0, 32'h0000_0333, 32'd50, 1'b0, 32'd0);
      branch("bex_t",  OP_BEX, 32'd1, 32'd0, 32'd0, 32'h0000_0333, 32'd50, 1'b1, 32'h0000_0333);

`ifdef MULTDIV_EN
      issue("mul",     OP_ALU, ALU_MUL, 5'd0, 32'hFFFF_FFFA, 32'd7, 32'd0, 5'd9, 32'hFFFF_FFD6, 5'd9, 33);
      issue("mul_b2b", OP_ALU, ALU_MUL, 5'd0, 32'd6, 32'd7, 32'd0, 5'd9, 32'd42, 5'd9, 33);
      issue("mul_ovf", OP_ALU, ALU_MUL, 5'd0, 32'h0001_0000, 32'h0001_0000, 32'd0, 5'd9, EXC_MUL, REG_STATUS, 33);
      issue("div",     OP_ALU, ALU_DIV, 5'd0, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd11, 32'hFFFF_FFFD, 5'd11, 33);
      issue("div0",    OP_ALU, ALU_DIV, 5'd0, 32'd9, 32'd0, 32'd0, 5'd11, EXC_DIV0, REG_STATUS, 33);

      drive(OP_ALU, ALU_MUL, 5'd0, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 5'd12);
      repeat (11) @(posedge clock);
      #1;
      XM_reset_n = 1'b0;
      @(posedge clock); #1;
      check("midrst_stall", {31'd0, stall}, 32'd0);
      check("midrst_result", XM_result, 32'd0);
      check("midrst_rd", {27'd0, XM_rd_address}, 32'd0);
      XM_reset_n = 1'b1;
      issue("mul_after_rst", OP_ALU, ALU_MUL, 5'd0, 32'd3, 32'd5, 32'd0, 5'd12, 32'd15, 5'd12, 33);
`else
      issue("mul_nomd", OP_ALU, ALU_MUL, 5'd0, 32'd6, 32'd7, 32'd0, 5'd9, 32'd0, 5'd9, 0);
      issue("div_nomd", OP_ALU, ALU_DIV, 5'd0, 32'd9, 32'd0, 32'd0, 5'd9, 32'd0, 5'd9, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
